// File: rtl/serial_adder.sv
// Bit-serial adder: one full-add per clock, LSB first, start/done handshake.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] opa, opb;
  logic             carry;
  logic [CW-1:0]    bitcnt;
  logic [WIDTH-2:0] acc;

  logic ha1_s, ha1_c, bit_s_c, ha2_c, carry_nxt_c;
  logic load_c, shift_c, last_c;

  // Full-add cell built from two cascaded half-adds.
  always_comb begin
    ha1_s       = opa[0] ^ opb[0];
    ha1_c       = opa[0] & opb[0];
    bit_s_c     = ha1_s ^ carry;
    ha2_c       = ha1_s & carry;
    carry_nxt_c = ha1_c | ha2_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_c    = 1'b0;
    shift_c   = 1'b0;
    last_c    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SHIFT;
          load_c    = 1'b1;
        end
      end
      SHIFT: begin
        shift_c = 1'b1;
        if (bitcnt == LAST) begin
          last_c    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status flags registered from next state so they track the state register exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_nxt == SHIFT);
      done <= (state_nxt == DONE);
    end
  end

  // Operand shift registers, carry, bit counter and result accumulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa    <= '0;
      opb    <= '0;
      carry  <= 1'b0;
      bitcnt <= '0;
      acc    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf    <= 1'b0;
`endif
    end else if (load_c) begin
      opa    <= a;
      opb    <= b;
      carry  <= cin;
      bitcnt <= '0;
      acc    <= '0;
    end else if (shift_c) begin
      opa   <= opa >> 1;
      opb   <= opb >> 1;
      carry <= carry_nxt_c;
      acc   <= (WIDTH-1)'({bit_s_c, acc} >> 1);
      if (last_c) begin
        // acc already holds the lower WIDTH-1 result bits; this edge adds the MSB.
        bitcnt <= '0;
        sum    <= {bit_s_c, acc};
        cout   <= carry_nxt_c;
`ifdef SERIAL_ADDER_OVF_EN
        ovf    <= carry ^ carry_nxt_c;
`endif
      end else begin
        bitcnt <= bitcnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): directed cases plus random
// operands compared against an arithmetic reference model.
module tb_serial_adder;

  localparam int unsigned WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a, b;
  logic             cin;
  logic             busy, done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  logic [WIDTH-1:0] exp_sum  = '0;
  logic             exp_cout = 1'b0;
  logic             exp_ovf  = 1'b0;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv)
    else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer arithmetic on the operands.
  task automatic model(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb, input logic tc);
    int unsigned u;
    int          s;
    u = int'(ta) + int'(tb) + int'(tc);
    s = int'($signed(ta)) + int'($signed(tb)) + int'(tc);
    exp_sum  = WIDTH'(u);
    exp_cout = (u >= (1 << WIDTH));
    exp_ovf  = (s > (1 << (WIDTH - 1)) - 1) || (s < -(1 << (WIDTH - 1)));
  endtask

  task automatic check_result(input string tag);
    chk({tag, "_sum"}, 32'(sum), 32'(exp_sum));
    chk({tag, "_cout"}, 32'(cout), 32'(exp_cout));
`ifdef SERIAL_ADDER_OVF_EN
    chk({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
`endif
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk("done_timeout", 32'(done), 32'(1));
  endtask

  // Full operation with timing checks; inputs are scrambled after capture.
  task automatic do_op(input string tag, input logic [WIDTH-1:0] ta,
                       input logic [WIDTH-1:0] tb, input logic tc);
    int n;
    a = ta; b = tb; cin = tc; start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < int'(WIDTH) + 4) begin
      chk({tag, "_busy"}, 32'(busy), 32'(1));
      chk({tag, "_hold"}, 32'(sum), 32'(exp_sum));
      a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
      tick();
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'(WIDTH));
    chk({tag, "_busy_done"}, 32'(busy), 32'(0));
    model(ta, tb, tc);
    check_result(tag);
    tick();
    chk({tag, "_done_pulse"}, 32'(done), 32'(0));
  endtask

  initial begin
    int n;
    logic [WIDTH-1:0] ra, rb;
    logic             rc;

    // Reset held with start asserted.
    rst_n = 1'b0; start = 1'b1; a = 8'h5A; b = 8'hA5; cin = 1'b1;
    #2;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_done", 32'(done), 32'(0));
      chk("rst_sum", 32'(sum), 32'(0));
      chk("rst_cout", 32'(cout), 32'(0));
    end
    start = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("post_rst_busy", 32'(busy), 32'(0));

    do_op("basic", 8'h3C, 8'h0F, 1'b0);
    chk("basic_val", 32'(sum), 32'h4B);
    do_op("carry", 8'hFF, 8'h01, 1'b0);
    chk("carry_val", 32'(sum), 32'h00);
    do_op("cin_ovf", 8'h7F, 8'h00, 1'b1);
    chk("cin_ovf_val", 32'(sum), 32'h80);

    // start pulses during SHIFT and DONE must be ignored.
    a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    start = 1'b1; a = 8'hAA; b = 8'h55;
    tick();
    start = 1'b0;
    wait_done(n);
    start = 1'b1;
    chk("ign_sum", 32'(sum), 32'h46);
    chk("ign_cout", 32'(cout), 32'(0));
    tick();
    start = 1'b0;
    chk("ign_done_clr", 32'(done), 32'(0));
    for (int i = 0; i < 3; i++) begin
      chk("ign_busy", 32'(busy), 32'(0));
      chk("ign_nodone", 32'(done), 32'(0));
      tick();
    end
    model(8'h12, 8'h34, 1'b0);
    check_result("ign");

    // Reset mid-operation.
    a = 8'hF0; b = 8'h0F; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'(0));
    chk("mid_rst_done", 32'(done), 32'(0));
    chk("mid_rst_sum", 32'(sum), 32'(0));
    chk("mid_rst_cout", 32'(cout), 32'(0));
    exp_sum = '0; exp_cout = 1'b0; exp_ovf = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("mid_rst_idle", 32'(busy), 32'(0));
    do_op("after_rst", 8'h01, 8'h01, 1'b1);
    chk("after_rst_val", 32'(sum), 32'h03);

    // start held high: back-to-back operations every WIDTH+2 cycles.
    a = 8'h05; b = 8'h06; cin = 1'b0; start = 1'b1;
    wait_done(n);
    chk("b2b_first", 32'(n), 32'(WIDTH + 1));
    chk("b2b_sum", 32'(sum), 32'h0B);
    tick();
    wait_done(n);
    chk("b2b_period", 32'(n + 1), 32'(WIDTH + 2));
    start = 1'b0;
    model(8'h05, 8'h06, 1'b0);
    check_result("b2b");
    tick();
    tick();
    chk("b2b_stop", 32'(busy), 32'(0));

    // Random operands.
    for (int i = 0; i < 25; i++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      rc = 1'($urandom);
      do_op("rand", ra, rb, rc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial adder for two WIDTH-bit operands plus carry-in.
- Processes one bit per clock, LSB first, through a full-add cell: two half-add stages plus a registered carry.
- Downstream of the half-add datapath: consumes its sum/carry terms each cycle and accumulates them into a WIDTH-bit result.
- Interface is a start/done handshake for the surrounding lab controller.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  operand A; captured when start is accepted
- b  input  WIDTH  operand B; captured when start is accepted
- cin  input  1  carry-in; captured when start is accepted
- busy  output  1  high while bits are being shifted
- done  output  1  one-cycle pulse when the result is valid
- sum  output  WIDTH  registered result; holds until next completion
- cout  output  1  registered carry-out; holds until next completion

Behaviour:
- Reset (rst_n low, asynchronous, any state):
  - state=IDLE; busy=0, done=0, sum=0, cout=0.
  - Internal operand, carry and counter registers cleared.
  - Takes effect immediately, no clock needed.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - On the edge where start=1 (edge k): load a->opA, b->opB, cin->carry, bitcnt=0; go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT, every edge:
  - s = opA[0]^opB[0]^carry, formed as two cascaded half-adds.
  - carry <= (opA[0]&opB[0]) | (carry&(opA[0]^opB[0])).
  - acc <= {s, acc[WIDTH-1:1]}; opA, opB shift right, zero-filled.
  - bitcnt <= bitcnt+1.
  - On the edge where bitcnt==WIDTH-1: go to DONE; load sum <= final acc and cout <= final carry.
- DONE: lasts exactly one cycle, then returns to IDLE unconditionally.
- Outputs: busy = (state==SHIFT); done = (state==DONE). Both derive from registered state, so there are no combinational paths from inputs.
- Latency:
  - Start accepted at edge k; shifts occur on edges k+1..k+WIDTH.
  - done is high between edges k+WIDTH and k+WIDTH+1.
  - Next start is accepted at edge k+WIDTH+2 at the earliest.
- start while busy or in DONE: ignored; no effect on operands or result.
- start held high continuously: back-to-back operations, one accepted every WIDTH+2 cycles.
- a, b, cin changing after capture: no effect on the current operation.
- sum/cout: stable from completion until the next completion, including throughout a following operation.
- bitcnt width: clog2(WIDTH) bits; never exceeds WIDTH-1.
- Reset mid-SHIFT: operation abandoned, outputs zero; a start after reset release behaves as from power-up.
- Arithmetic: unsigned sum modulo 2^WIDTH; cout is bit WIDTH of a+b+cin.

Optional Feature:
- Macro: SERIAL_ADDER_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit, registered, reset 0).
  - ovf = signed overflow = (carry into MSB) ^ (carry out of MSB), captured on the final shift edge.
  - Loaded and held together with sum/cout.
- Undefined: no ovf port and no ovf logic; all other behaviour identical.

Test Plan (WIDTH=8):
- Reset test: hold rst_n=0 for 3 cycles with start=1 -> busy=0, done=0, sum=8'h00, cout=0 throughout; no operation starts.
- Basic add and timing: a=8'h3C, b=8'h0F, cin=0, start pulsed at edge k -> busy high for 8 cycles; done high only between edges k+8 and k+9; sum=8'h4B, cout=0.
- Carry out: a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1; ovf=0 when SERIAL_ADDER_OVF_EN is defined.
- Carry-in and signed overflow: a=8'h7F, b=8'h00, cin=1 -> sum=8'h80, cout=0; ovf=1 when the macro is defined.
- Start ignored when busy: start with a=8'h12, b=8'h34; pulse start with a=8'hAA, b=8'h55 at shift 3 and again in DONE -> sum=8'h46, single done pulse, no second operation.
- Reset mid-op: start a=8'hF0, b=8'h0F; drop rst_n after 4 shifts -> outputs 0 at once; after release, a=8'h01, b=8'h01, cin=1 gives sum=8'h03, cout=0.
